// File: rtl/comparator_serial_fsm.sv
// Bit-serial MSB-first magnitude comparator, one-hot F1(>)/F2(==)/F3(<) result per start/done frame.
// Latency: start cycle + WIDTH accepted bits, then done pulses on the following cycle.
// Backpressure: none; bit_valid=0 stalls the frame indefinitely, start is ignored unless idle.
module comparator_serial_fsm #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic A,
    input  logic C,
    output logic busy,
    output logic done,
    output logic F1,
    output logic F2,
    output logic F3
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             decided;
    logic             rel_gt;
    logic             rel_lt;

    logic gt_nxt;
    logic lt_nxt;
    logic last_bit;

    // The first differing bit pair (MSB-first) fixes the relation; later bits only advance the count.
    always_comb begin
        gt_nxt   = decided ? rel_gt : (A & ~C);
        lt_nxt   = decided ? rel_lt : (~A & C);
        last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    end

    assign busy = (state == S_COMPARE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            decided <= 1'b0;
            rel_gt  <= 1'b0;
            rel_lt  <= 1'b0;
            done    <= 1'b0;
            F1      <= 1'b0;
            F2      <= 1'b0;
            F3      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_COMPARE;
                        bit_cnt <= '0;
                        decided <= 1'b0;
                        rel_gt  <= 1'b0;
                        rel_lt  <= 1'b0;
                        F1      <= 1'b0;
                        F2      <= 1'b0;
                        F3      <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (bit_valid) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        decided <= decided | (A ^ C);
                        rel_gt  <= gt_nxt;
                        rel_lt  <= lt_nxt;
                        // Flags are loaded on the edge entering DONE so they are valid alongside done.
                        if (last_bit) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            F1    <= gt_nxt;
                            F2    <= ~gt_nxt & ~lt_nxt;
                            F3    <= lt_nxt;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial_fsm.sv
// Self-checking bench for comparator_serial_fsm: directed scenarios plus random frames vs. an integer compare model.
module tb_comparator_serial_fsm;

    localparam int W        = 4;
    localparam int MAX_ITER = 80;

    logic clk = 1'b0;
    logic rst, start, bit_valid, A, C;
    logic busy, done, F1, F2, F3;

    int vectors    = 0;
    int miscompares = 0;

    // Observations of the most recent frame
    int         done_lat;
    int         busy_cycles;
    int         done_cnt;
    int         busy_after;
    logic [2:0] flags_done;
    logic [2:0] flags_first;

    always #5 clk = ~clk;

    comparator_serial_fsm #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bit_valid(bit_valid),
        .A        (A),
        .C        (C),
        .busy     (busy),
        .done     (done),
        .F1       (F1),
        .F2       (F2),
        .F3       (F3)
    );

    function automatic logic [2:0] model(input logic [W-1:0] p, input logic [W-1:0] q);
        int ip = int'(p);
        int iq = int'(q);
        return {ip > iq, ip == iq, ip < iq};
    endfunction

    // Iteration i observes cycle i (start sampled at the end of cycle 0), then drives cycle i's inputs.
    task automatic drive_frame(input logic [W-1:0] p, input logic [W-1:0] q,
                               input int gap_after, input int gap_len,
                               input int start_pulse_iter, input bit start_in_done,
                               input bit stop_at_done);
        int b = 0;
        int gaps_left = gap_len;
        done_lat    = -1;
        busy_cycles = 0;
        done_cnt    = 0;
        busy_after  = 0;
        flags_done  = 3'b000;
        flags_first = 3'bxxx;
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b0; A = 1'b0; C = 1'b0;
        for (int i = 1; i <= MAX_ITER; i++) begin
            @(negedge clk);
            if (i == 1) flags_first = {F1, F2, F3};
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (done_lat < 0) begin
                    done_lat   = i;
                    flags_done = {F1, F2, F3};
                end
            end
            if (done_lat >= 0 && i > done_lat && busy) busy_after++;
            start = (i == start_pulse_iter) || (start_in_done && i == done_lat);
            bit_valid = 1'b0; A = 1'b0; C = 1'b0;
            if (b < W && done_lat < 0) begin
                if (b == gap_after && gaps_left > 0) begin
                    gaps_left--;
                end else begin
                    bit_valid = 1'b1;
                    A = p[W-1-b];
                    C = q[W-1-b];
                    b++;
                end
            end
            if (stop_at_done && done_lat >= 0) break;
            if (done_lat >= 0 && i >= done_lat + 3) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; A = 1'b0; C = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, F1, F2, F3} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: busy/done/F = %b, expected 00000", i, {busy, done, F1, F2, F3});
            end
        end
    endtask

    task automatic test_gt_no_gaps();
        drive_frame(4'b1010, 4'b1001, -1, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (done_lat !== W + 1) begin
            miscompares++;
            $display("FAIL gt_latency: done at %0d, expected %0d", done_lat, W + 1);
        end
        vectors++;
        if (flags_done !== 3'b100) begin
            miscompares++;
            $display("FAIL gt_flags: F1F2F3=%b, expected 100", flags_done);
        end
        vectors++;
        if ({F1, F2, F3} !== 3'b100) begin
            miscompares++;
            $display("FAIL gt_flags_hold: F1F2F3=%b, expected 100 after done", {F1, F2, F3});
        end
    endtask

    task automatic test_eq_with_gaps();
        drive_frame(4'b0011, 4'b0011, 2, 2, 0, 1'b0, 1'b0);
        vectors++;
        if (done_lat !== 7) begin
            miscompares++;
            $display("FAIL eq_latency: done at %0d, expected 7", done_lat);
        end
        vectors++;
        if (busy_cycles !== 6) begin
            miscompares++;
            $display("FAIL eq_busy_cycles: busy for %0d, expected 6", busy_cycles);
        end
        vectors++;
        if (flags_done !== 3'b010) begin
            miscompares++;
            $display("FAIL eq_flags: F1F2F3=%b, expected 010", flags_done);
        end
    endtask

    task automatic test_lt_start_ignored();
        drive_frame(4'b0111, 4'b1000, -1, 0, 2, 1'b1, 1'b0);
        vectors++;
        if (flags_done !== 3'b001) begin
            miscompares++;
            $display("FAIL lt_flags: F1F2F3=%b, expected 001", flags_done);
        end
        vectors++;
        if (done_lat !== W + 1 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL lt_done_once: done at %0d count %0d, expected %0d count 1", done_lat, done_cnt, W + 1);
        end
        vectors++;
        if (busy_cycles !== W || busy_after !== 0) begin
            miscompares++;
            $display("FAIL lt_start_ignored: busy %0d after-done busy %0d, expected %0d and 0", busy_cycles, busy_after, W);
        end
    endtask

    task automatic test_midframe_reset();
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b1; A = 1'b1; C = 1'b0;
        @(negedge clk);
        A = 1'b1; C = 1'b1;
        @(negedge clk);
        rst = 1'b1; bit_valid = 1'b1; A = 1'b1; C = 1'b0;
        @(negedge clk);
        rst = 1'b0; bit_valid = 1'b1;
        vectors++;
        if ({busy, done, F1, F2, F3} !== 5'b00000) begin
            miscompares++;
            $display("FAIL midreset_state: busy/done/F = %b, expected 00000", {busy, done, F1, F2, F3});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_no_done cycle %0d: busy=%b done=%b, expected 0 0", i, busy, done);
            end
        end
        bit_valid = 1'b0;
        drive_frame(4'b1111, 4'b1110, -1, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (flags_done !== 3'b100 || done_lat !== W + 1) begin
            miscompares++;
            $display("FAIL midreset_next_frame: F1F2F3=%b lat %0d, expected 100 lat %0d", flags_done, done_lat, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        drive_frame(4'b0101, 4'b0110, -1, 0, 0, 1'b0, 1'b1);
        vectors++;
        if (flags_done !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_first_flags: F1F2F3=%b, expected 001", flags_done);
        end
        drive_frame(4'b1100, 4'b0011, -1, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (flags_first !== 3'b000) begin
            miscompares++;
            $display("FAIL b2b_flags_clear: F1F2F3=%b after start, expected 000", flags_first);
        end
        vectors++;
        if (done_lat !== W + 1 || flags_done !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_second: lat %0d F1F2F3=%b, expected lat %0d 100", done_lat, flags_done, W + 1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] p, q;
            int ga, gl;
            logic [2:0] exp_flags;
            p  = W'($urandom);
            q  = (n % 4 == 0) ? p : W'($urandom);
            ga = int'($urandom_range(0, W - 1));
            gl = int'($urandom_range(0, 3));
            exp_flags = model(p, q);
            drive_frame(p, q, ga, gl, 0, 1'b0, (n % 2) == 1);
            vectors++;
            if (flags_done !== exp_flags) begin
                miscompares++;
                $display("FAIL rand_flags P=%b Q=%b: F1F2F3=%b, expected %b", p, q, flags_done, exp_flags);
            end
            vectors++;
            if (done_lat !== W + 1 + gl || done_cnt !== 1) begin
                miscompares++;
                $display("FAIL rand_latency P=%b Q=%b gaps=%0d: done at %0d count %0d, expected %0d count 1",
                         p, q, gl, done_lat, done_cnt, W + 1 + gl);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; A = 1'b0; C = 1'b0;
        test_reset();
        test_gt_no_gaps();
        test_eq_with_gaps();
        test_lt_start_ignored();
        test_midframe_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
